// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: loader FSM state type and stream framing constants.
// CHK state exists only when ROM_LOADER_CHECKSUM_EN is defined.
package rom_loader_pkg;
  localparam int LEN_BYTES = 2;
  localparam int WORD_BYTES = 2;
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
`ifdef ROM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
endpackage

// File: rtl/rom_loader.sv
// rom_loader: byte-stream program loader that writes 16-bit words into the Hack instruction ROM.
// Ports: clk, reset (async, active-high); start begins a load; byte_valid/byte_data/byte_ready
// form the input byte handshake; rom_we/rom_addr/rom_wdata drive the ROM write port;
// cpu_reset holds the computer until done; error flags an aborted load; word_count counts writes.
// Optional macro ROM_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);
  localparam logic [32:0] CAP = 33'(1) << ADDR_WIDTH;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] sum;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, nxt;
  logic [LEN_BYTES*8-1:0] len, nlen;
  logic [(WORD_BYTES-1)*8-1:0] hi;
  logic xfer, more, idle_like;
  always_comb begin
    xfer = byte_valid && byte_ready;
    nlen = {len[15:8], byte_data};
    more = 32'(word_count) + 32'd1 < 32'(len);
    idle_like = state == IDLE || state == DONE || state == ERROR;
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = start ? LEN_HI : state;
      LEN_HI:  nxt = xfer ? LEN_LO : state;
      LEN_LO:  nxt = !xfer ? state : (nlen == '0) ? FIN : (33'(nlen) > CAP) ? ERROR : DATA_HI;
      DATA_HI: nxt = xfer ? DATA_LO : state;
      DATA_LO: nxt = xfer ? WRITE : state;
      WRITE:   nxt = more ? DATA_HI : FIN;
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK:     nxt = !xfer ? state : (byte_data == sum) ? DONE : ERROR;
`endif
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they change together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      cpu_reset <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      rom_we <= 1'b0;
      rom_addr <= '0;
      rom_wdata <= '0;
      word_count <= '0;
      len <= '0;
      hi <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= nxt;
      byte_ready <= nxt == LEN_HI || nxt == LEN_LO || nxt == DATA_HI || nxt == DATA_LO
`ifdef ROM_LOADER_CHECKSUM_EN
                    || nxt == CHK
`endif
                    ;
      cpu_reset <= nxt != DONE;
      done <= nxt == DONE;
      error <= nxt == ERROR;
      rom_we <= nxt == WRITE;
      if (start && idle_like) word_count <= '0;
      if (xfer && state == LEN_HI) len[15:8] <= byte_data;
      if (xfer && state == LEN_LO) len[7:0] <= byte_data;
      if (xfer && state == DATA_HI) hi <= byte_data;
      if (xfer && state == DATA_LO) begin
        rom_addr <= word_count[ADDR_WIDTH-1:0];
        rom_wdata <= {hi, byte_data};
      end
      if (state == WRITE) word_count <= word_count + (ADDR_WIDTH+1)'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
      if (start && idle_like) sum <= '0;
      else if (xfer && (state == DATA_HI || state == DATA_LO)) sum <= sum + byte_data;
`endif
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader; expected ROM writes are queued by stimulus and popped by a monitor.
module tb_rom_loader;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [7:0] byte_data = 8'hEE;
  logic byte_ready, rom_we, cpu_reset, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic [15:0] word_count;
  int errors = 0, checks = 0;
  logic [30:0] exp_q[$];
  logic [15:0] img[4];

  rom_loader #(.ADDR_WIDTH(15)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [30:0] e;
    if (!reset && rom_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", rom_addr, rom_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("rom_write", {1'b0, rom_addr, rom_wdata}, {1'b0, e});
      end
    end
  end

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    byte_valid = 1;
    byte_data = b;
    while (!byte_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h got byte_ready 0 expected 1", b);
    end
    @(posedge clk); #1;
    byte_valid = 0;
    byte_data = 8'hEE;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: got done=0 error=0 expected one of them set");
    end
  endtask

  task automatic load(input int n, input bit gap);
    logic [7:0] s;
    s = 0;
    send(8'(n >> 8), gap);
    send(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({15'(i), img[i]});
      send(img[i][15:8], gap);
      send(img[i][7:0], gap);
      s = s + img[i][15:8] + img[i][7:0];
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    send(s, gap);
`endif
    wait_end();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_wdata", rom_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_byte_ready", byte_ready, 0);
    chk("idle_cpu_reset", cpu_reset, 1);

    img[0] = 16'h1234; img[1] = 16'hABCD;
    pulse_start();
    chk("start_byte_ready", byte_ready, 1);
    load(2, 0);
    chk("t1_done", done, 1);
    chk("t1_cpu_reset", cpu_reset, 0);
    chk("t1_word_count", word_count, 2);
    chk("t1_error", error, 0);
    chk("t1_hold_addr", rom_addr, 1);
    chk("t1_hold_wdata", rom_wdata, 16'hABCD);
    chk("t1_queue_empty", exp_q.size(), 0);

    pulse_start();
    chk("restart_cpu_reset", cpu_reset, 1);
    chk("restart_done", done, 0);
    chk("restart_word_count", word_count, 0);
    load(0, 0);
    chk("t2_done", done, 1);
    chk("t2_cpu_reset", cpu_reset, 0);
    chk("t2_word_count", word_count, 0);

    pulse_start();
    send(8'h80, 0);
    send(8'h01, 0);
    wait_end();
    byte_valid = 1;
    byte_data = 8'h12;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 0;
    chk("t3_error", error, 1);
    chk("t3_cpu_reset", cpu_reset, 1);
    chk("t3_byte_ready", byte_ready, 0);
    chk("t3_done", done, 0);

    img[0] = 16'hDEAD; img[1] = 16'hBEEF; img[2] = 16'h0102;
    pulse_start();
    chk("t4_error_cleared", error, 0);
    load(3, 1);
    chk("t4_done", done, 1);
    chk("t4_word_count", word_count, 3);
    chk("t4_queue_empty", exp_q.size(), 0);

    pulse_start();
    send(8'h00, 0);
    send(8'h03, 0);
    exp_q.push_back({15'd0, 16'h1111});
    send(8'h11, 0);
    send(8'h11, 0);
    @(posedge clk); #1;
    chk("t5_mid_count", word_count, 1);
    #2 reset = 1;
    #1;
    chk("t5_rst_byte_ready", byte_ready, 0);
    chk("t5_rst_cpu_reset", cpu_reset, 1);
    chk("t5_rst_word_count", word_count, 0);
    chk("t5_rst_done", done, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    img[0] = 16'h5555; img[1] = 16'hAAAA;
    pulse_start();
    load(2, 0);
    chk("t5_done", done, 1);
    chk("t5_word_count", word_count, 2);
    chk("t5_queue_empty", exp_q.size(), 0);

`ifdef ROM_LOADER_CHECKSUM_EN
    pulse_start();
    exp_q.push_back({15'd0, 16'h1234});
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h46, 0);
    wait_end();
    chk("t6_good_done", done, 1);
    chk("t6_good_error", error, 0);
    pulse_start();
    exp_q.push_back({15'd0, 16'h1234});
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h47, 0);
    wait_end();
    chk("t6_bad_error", error, 1);
    chk("t6_bad_cpu_reset", cpu_reset, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader sitting directly upstream of the Hack computer. Receives a program image as a byte stream and assembles big-endian 16-bit words. Writes each word into the computer's instruction ROM through a write port. Holds the computer in reset until the image is fully written, so a board build can load programs at runtime instead of from a fixed ROM file.

## Interface
Parameters:
- ADDR_WIDTH, 15, ROM address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready at a rising edge.
- rom_we  output  1  ROM write strobe, one cycle per word.
- rom_addr  output  ADDR_WIDTH  ROM write address.
- rom_wdata  output  16  ROM write data.
- cpu_reset  output  1  drives the computer's reset input.
- done  output  1  image loaded; computer released.
- error  output  1  load aborted; computer held in reset.
- word_count  output  ADDR_WIDTH+1  words written in the current or last load.

## Operation
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent as high byte then low byte.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR (plus CHK when configured).
- IDLE: cpu_reset=1, byte_ready=0. start moves to LEN_HI and clears word_count.
- LEN_HI -> LEN_LO -> DATA_HI, each on a byte transfer.
- After LEN_LO, the state depends on N:
  - N==0: go to DONE (or CHK).
  - N>2^ADDR_WIDTH: go to ERROR.
- DATA_HI latches the high byte, then DATA_LO latches the low byte, then WRITE.
- WRITE, one cycle:
  - rom_we=1, rom_addr=word_count[ADDR_WIDTH-1:0], rom_wdata={hi,lo}.
  - word_count increments at the end of the cycle.
  - Next state is DATA_HI if word_count+1<N, otherwise DONE (or CHK).
- byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK.
- DONE: cpu_reset=0, done=1. start re-enters LEN_HI and reasserts cpu_reset the next cycle.
- ERROR: cpu_reset=1, error=1. Only start or reset leaves this state.
- start outside IDLE/DONE/ERROR is ignored.
- rom_addr and rom_wdata are registered and hold their last value when rom_we=0.

## Timing
- Reset values: state=IDLE, cpu_reset=1, byte_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, done=0, error=0, word_count=0.
- Reset mid-load returns to IDLE asynchronously. Partial ROM contents are left as-is.
- Latency: rom_we asserts exactly one cycle after the low-byte transfer.
- Minimum 3 cycles per word, because byte_ready=0 during WRITE.
- cpu_reset falls in the cycle DONE is entered. No handshake is needed downstream.
- Max N (2^ADDR_WIDTH): the last write goes to address 2^ADDR_WIDTH-1. word_count reaches 2^ADDR_WIDTH without wrapping.
- byte_valid while byte_ready=0: the byte is not consumed, and the source must hold it.

## Configuration
- ROM_LOADER_CHECKSUM_EN defined:
  - After the last word (or after LEN_LO when N==0), state CHK accepts one byte.
  - Expected value: 8-bit modulo-256 sum of all data bytes, excluding the length bytes.
  - Match goes to DONE; mismatch goes to ERROR.
- Not defined: no CHK state, no trailing byte, and no sum register.

## Structure
- Package rom_loader_pkg holds:
  - the state enum;
  - the LEN_BYTES=2 constant;
  - the WORD_BYTES=2 constant.
- Single module with no sub-module. The byte pairing is too small to justify one.
- The top level instantiates rom_loader beside the computer and wires cpu_reset to the computer's reset input. rom_we/rom_addr/rom_wdata go to the ROM's added write port.

## Test plan
- Reset, then start, then bytes 00 02 12 34 AB CD -> rom writes (0,0x1234), (1,0xABCD); done=1, cpu_reset=0, word_count=2.
- Length 00 00 -> DONE directly, with no rom_we pulses.
- Length 80 01 with ADDR_WIDTH=15 -> error=1, cpu_reset stays 1, byte_ready=0.
- byte_valid toggled randomly on a 3-word image -> same writes and addresses as the gap-free run; no byte dropped or duplicated.
- Reset asserted after the first data word, then a new full load -> state IDLE immediately, then the correct reload from address 0.
- With ROM_LOADER_CHECKSUM_EN, image 00 01 12 34 plus checksum 46 -> done=1. Same image with checksum 47 -> error=1.
